// File: rtl/adder_stim_checker.sv
// adder_stim_checker
// Stimulus source and result checker for the full-adder datapath block.
// Drives LFSR operands into the adder, delays a golden expectation by the
// adder's pipeline latency and compares the adder output against it.
// Reports pass/fail, a saturating mismatch count and the first failing
// vector index.
module adder_stim_checker #(
    parameter int          WIDTH       = 32,
    parameter int          LATENCY     = 2,
    parameter int          WARMUP      = 4,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE12345,
    parameter logic        CIN         = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic [WIDTH-1:0] dut_data_in_o,
    input  logic [WIDTH-1:0] dut_data_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [15:0]      err_count_o,
    output logic [15:0]      first_err_idx_o
);

    localparam int          H         = WIDTH / 2;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] WARM_LAST = 32'(WARMUP - 1);
    localparam logic [31:0] RUN_LAST  = 32'(NUM_VECTORS - 1);
    localparam logic [31:0] DRN_LAST  = 32'(LATENCY - 1);
    localparam logic [15:0] NO_ERR    = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Fit the 32-bit LFSR word to the bus: truncate or zero-extend.
    function automatic logic [WIDTH-1:0] widen(input logic [31:0] x);
        logic [WIDTH+31:0] t;
        t = {{WIDTH{1'b0}}, x};
        return t[WIDTH-1:0];
    endfunction

    // Expected adder result for an operand word {b, a}.
    function automatic logic [WIDTH-1:0] golden_exp(input logic [WIDTH-1:0] v);
        logic [H-1:0] a;
        logic [H-1:0] b;
        a = v[H-1:0];
        b = v[WIDTH-1:H];
        return {{H{1'b1}}, a ^ b ^ {{(H-1){1'b0}}, CIN}};
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       lfsr_q;
    logic [WIDTH-1:0]  dut_data_in_q;
    logic              busy_q, done_q, pass_q;
    logic [15:0]       err_q, err_d;
    logic [15:0]       first_q, first_d;

    // Compare pipeline: expectation for the word currently on the bus enters
    // stage 0 at the end of its cycle and reaches the last stage exactly when
    // the adder presents the matching result.
    logic              vld_p [LATENCY];
    logic [15:0]       idx_p [LATENCY];
    logic [WIDTH-1:0]  exp_p [LATENCY];

    logic              start_acc;
    logic              mismatch;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign mismatch  = vld_p[LATENCY-1] && (dut_data_out_i != exp_p[LATENCY-1]);

    // Next-state, phase counter and error bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WARMUP;
                    cnt_d   = 32'd0;
                end
            end
            S_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        if (start_acc) begin
            err_d   = 16'd0;
            first_d = NO_ERR;
        end else if (mismatch) begin
            err_d = sat_inc(err_q);
            if (first_q == NO_ERR) begin
                first_d = idx_p[LATENCY-1];
            end
        end
    end

    // Sequencer state, LFSR, registered outputs and compare pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            lfsr_q        <= SEED_EFF;
            dut_data_in_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= 16'd0;
            first_q       <= NO_ERR;
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                idx_p[i] <= 16'd0;
                exp_p[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_WARMUP) || (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            err_q   <= err_d;
            first_q <= first_d;

            if (start_acc) begin
                lfsr_q <= SEED_EFF;
            end else if (state_d == S_RUN) begin
                lfsr_q <= lfsr_next(lfsr_q);
            end

            dut_data_in_q <= (state_d == S_RUN) ? widen(lfsr_q) : '0;

            if (start_acc) begin
                pass_q <= 1'b0;
            end else if (state_d == S_DONE) begin
                pass_q <= (err_d == 16'd0);
            end

            // stage 0: expectation of the word driven during this cycle
            vld_p[0] <= (state_q == S_RUN);
            idx_p[0] <= cnt_q[15:0];
            exp_p[0] <= golden_exp(dut_data_in_q);
            // stages 1..LATENCY-1: pure delay
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
                exp_p[i] <= exp_p[i-1];
            end
        end
    end

    assign dut_data_in_o   = dut_data_in_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_count_o     = err_q;
    assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// tb_adder_stim_checker
// Bench for adder_stim_checker: a behavioural adder with selectable faults
// sits on the data interface; expected run results are queued at start and
// compared when the checker reports done.
module tb_adder_stim_checker;

    localparam int          WIDTH = 32;
    localparam int          WARM  = 4;
    localparam int          NVEC  = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] SEED  = 32'hACE12345;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start6 = 1'b0;
    logic [31:0] din, dout, din6, dout6;
    logic        busy, done, pass, busy6, done6, pass6;
    logic [15:0] err, first, err6, first6;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    adder_stim_checker u_dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .dut_data_in_o   (din),
        .dut_data_out_i  (dout),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_count_o     (err),
        .first_err_idx_o (first)
    );

    adder_stim_checker #(
        .WIDTH(32), .LATENCY(1), .WARMUP(1), .NUM_VECTORS(1),
        .SEED(SEED), .CIN(1'b1)
    ) u_dut6 (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start6),
        .dut_data_in_o   (din6),
        .dut_data_out_i  (dout6),
        .busy_o          (busy6),
        .done_o          (done6),
        .pass_o          (pass6),
        .err_count_o     (err6),
        .first_err_idx_o (first6)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] adder_ref(input logic [31:0] x);
        return {16'hFFFF, x[15:0] ^ x[31:16] ^ 16'h0001};
    endfunction

    // Adder model: 0 correct, 1 flip bit0 on vector 5, 2 upper half zero,
    // 3 one extra cycle of latency.
    int          mode = 0;
    logic [31:0] v5;
    logic [31:0] r1, r2, r3, r6;

    function automatic logic [31:0] model_f(input logic [31:0] x);
        logic [31:0] g;
        g = adder_ref(x);
        if (mode == 1 && x == v5) g[0] = ~g[0];
        if (mode == 2) g[31:16] = 16'h0000;
        return g;
    endfunction

    always_ff @(posedge clk) begin
        r1 <= model_f(din);
        r2 <= r1;
        r3 <= r2;
        r6 <= adder_ref(din6);
    end

    assign dout  = (mode == 3) ? r3 : r2;
    assign dout6 = r6;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    typedef struct {
        int          cycles;
        logic        pass;
        logic [15:0] err;
        logic [15:0] first;
        bit          err_ge;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int cyc, input logic p, input logic [15:0] e,
                            input logic [15:0] f, input bit ge);
        exp_t x;
        x.cycles = cyc; x.pass = p; x.err = e; x.first = f; x.err_ge = ge;
        sb.push_back(x);
    endtask

    // One run on the default instance; optional reset abort, optional
    // start pulse while busy, optional per-cycle bus check.
    task automatic run_a(input string tn, input int rst_at, input int restart_at, input bit chk_vec);
        int          cyc;
        bit          got;
        logic [31:0] v, ev;
        exp_t        x;
        v = SEED; got = 0; cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 1000 && !got) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc >= WARM && cyc < WARM + NVEC) begin
                ev = v; v = lfsr_step(v);
            end else begin
                ev = 32'h0;
            end
            if (chk_vec) check({tn, "_vec"}, din, ev);
            if (cyc == rst_at) begin
                rst = 1'b0;
                @(posedge clk); #1;
                check({tn, "_busy"}, busy, 1'b0);
                check({tn, "_din"}, din, 32'h0);
                check({tn, "_err"}, err, 16'h0);
                check({tn, "_first"}, first, 16'hFFFF);
                check({tn, "_done"}, done, 1'b0);
                rst = 1'b1;
                return;
            end
            got = done;
        end
        start = 1'b0;
        if (!got) check({tn, "_timeout"}, 1'b0, 1'b1);
        if (sb.size() == 0) begin
            check({tn, "_sb_empty"}, 1'b0, 1'b1);
            return;
        end
        x = sb.pop_front();
        check({tn, "_cycles"}, cyc, x.cycles);
        check({tn, "_pass"}, pass, x.pass);
        if (x.err_ge) check({tn, "_err_ge255"}, (err >= 16'd255), 1'b1);
        else check({tn, "_err"}, err, x.err);
        check({tn, "_first"}, first, x.first);
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tn, "_done_pulse"}, done, 1'b0);
        check({tn, "_idle_busy"}, busy, 1'b0);
        @(posedge clk); #1;
        check({tn, "_no_restart"}, busy, 1'b0);
        check({tn, "_pass_hold"}, pass, x.pass);
    endtask

    initial begin
        int   c;
        bit   got;
        exp_t xe;

        v5 = SEED;
        for (int i = 0; i < 5; i++) v5 = lfsr_step(v5);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err, 16'h0);
        check("rst_first", first, 16'hFFFF);
        check("rst_din", din, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        mode = 0;
        push_exp(WARM + NVEC + LAT, 1'b1, 16'd0, 16'hFFFF, 1'b0);
        run_a("t1", -1, -1, 1'b1);

        mode = 1;
        push_exp(WARM + NVEC + LAT, 1'b0, 16'd1, 16'd5, 1'b0);
        run_a("t2", -1, -1, 1'b0);

        mode = 2;
        push_exp(WARM + NVEC + LAT, 1'b0, 16'd256, 16'd0, 1'b0);
        run_a("t3", -1, -1, 1'b0);

        mode = 3;
        push_exp(WARM + NVEC + LAT, 1'b0, 16'd0, 16'd0, 1'b1);
        run_a("t4", -1, -1, 1'b0);

        mode = 0;
        run_a("t5_rst", WARM + 100, -1, 1'b0);
        @(posedge clk); #1;
        push_exp(WARM + NVEC + LAT, 1'b1, 16'd0, 16'hFFFF, 1'b0);
        run_a("t5", -1, 50, 1'b1);

        push_exp(3, 1'b1, 16'd0, 16'hFFFF, 1'b0);
        start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        c = 0; got = 0;
        while (c < 50 && !got) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) check("t6_vec", din6, SEED);
            if (c == 2) check("t6_vec_zero", din6, 32'h0);
            got = done6;
        end
        if (!got) check("t6_timeout", 1'b0, 1'b1);
        xe = sb.pop_front();
        check("t6_cycles", c, xe.cycles);
        check("t6_pass", pass6, xe.pass);
        check("t6_err", err6, xe.err);
        check("t6_first", first6, xe.first);
        check("t6_busy_in_done", busy6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
